popcount_seq: RTL

POPCOUNT_SEQ -- requirements
Module: popcount_seq

---
 rtl/popcount_pkg.sv | 23 ++
 rtl/nib_ones4.sv | 17 +
 rtl/popcount_seq.sv | 93 +++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// ============================================================================
// Module      : popcount_pkg
// Description : Shared state encoding and count-width helper for popcount_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package popcount_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to hold a count from 0 up to and including w.
   function automatic int cw_of(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/nib_ones4.sv
// ============================================================================
// Module      : nib_ones4
// Description : Combinational ones-count of a 4-bit nibble (0..4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nib_ones4 (
   input  logic [3:0] nib,
   output logic [2:0] ones
);

   assign ones = {2'b00, nib[0]} + {2'b00, nib[1]} + {2'b00, nib[2]} + {2'b00, nib[3]};

endmodule

`default_nettype wire

// File: rtl/popcount_seq.sv
// ============================================================================
// Module      : popcount_seq
// Description : Sequential popcount, one nibble per cycle, valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_seq
   import popcount_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int NIBS  = WIDTH / 4,
   localparam int CW    = cw_of(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic          in_ready,
   input  logic          abort,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_count,
   output logic          out_all_ones,
   output logic          out_parity
);

   localparam int IW = (NIBS > 1) ? $clog2(NIBS) : 1;
   localparam logic [IW-1:0] c_last_idx = IW'(NIBS - 1);
   localparam logic [CW-1:0] c_full     = CW'(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_acc;
   logic [IW-1:0]    r_idx;
   logic [2:0]       w_nib_ones;

   // A single nibble counter is shared across all steps of a job.
   nib_ones4 u_nib (
      .nib  (r_shift[3:0]),
      .ones (w_nib_ones)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)             w_next = ST_RUN;
         ST_RUN:  if (r_idx == c_last_idx)  w_next = ST_DONE;
         ST_DONE: if (out_ready)            w_next = ST_IDLE;
         default:                           w_next = ST_IDLE;
      endcase
      if (abort) w_next = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_next;
         if (abort) begin
            r_acc <= '0;
            r_idx <= '0;
         end else begin
            case (r_state)
               ST_IDLE: if (in_valid) begin
                  r_shift <= in_data;
                  r_acc   <= '0;
                  r_idx   <= '0;
               end
               ST_RUN: begin
                  r_acc   <= r_acc + {{(CW-3){1'b0}}, w_nib_ones};
                  r_shift <= r_shift >> 4;
                  r_idx   <= r_idx + IW'(1);
               end
               default: ;
            endcase
         end
      end
   end

   assign in_ready     = (r_state == ST_IDLE);
   assign out_valid    = (r_state == ST_DONE);
   assign out_count    = r_acc;
   assign out_all_ones = (r_acc == c_full);
   assign out_parity   = r_acc[0];

endmodule

`default_nettype wire
